// File: rtl/encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : encoder_pkg
// Brief    : Shared quadrature state encoding and defaults for encoder_emulator
// Revision : 1.0
// ============================================================================
package encoder_pkg;

  localparam int unsigned c_DEF_CLK_HZ        = 50_000_000;
  localparam int unsigned c_DEF_EDGES_PER_REV = 32;
  localparam int unsigned c_RPM_W             = 11;
  localparam int unsigned c_POS_W             = 16;

  // State code is {A,B} so the channels come straight off the state register.
  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b10,
    S2 = 2'b11,
    S3 = 2'b01
  } quad_state_t;

  // Successor tables indexed by state code, two bits per entry.
  localparam logic [7:0] c_FWD_NEXT = 8'b01_11_00_10;
  localparam logic [7:0] c_REV_NEXT = 8'b10_00_11_01;

  function automatic quad_state_t quad_next(input quad_state_t s, input logic fwd);
    logic [7:0] tbl;
    tbl = fwd ? c_FWD_NEXT : c_REV_NEXT;
    return quad_state_t'(tbl[{s, 1'b0} +: 2]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/enc_rate_nco.sv
`default_nettype none
// ============================================================================
// Module   : enc_rate_nco
// Brief    : Modulo phase accumulator producing the per-cycle step decision
// Revision : 1.0
// ============================================================================
module enc_rate_nco
  import encoder_pkg::*;
#(
  parameter longint unsigned MOD   = 64'(c_DEF_CLK_HZ) * 64'd60,
  parameter int unsigned     ACC_W = $clog2(MOD) + 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             enable,
  input  logic [ACC_W-1:0] inc,
  output logic             step
);

  localparam logic [ACC_W-1:0] c_MOD = ACC_W'(MOD);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_sum;
  logic             w_wrap;

  // acc < MOD and inc <= MOD, so the sum always fits in ACC_W bits.
  always_comb begin
    w_sum  = r_acc + inc;
    w_wrap = (w_sum >= c_MOD);
    step   = enable && w_wrap;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_acc <= '0;
    end else if (!enable) begin
      r_acc <= '0;
    end else if (w_wrap) begin
      r_acc <= w_sum - c_MOD;
    end else begin
      r_acc <= w_sum;
    end
  end

endmodule
`default_nettype wire

// File: rtl/encoder_emulator.sv
`default_nettype none
// ============================================================================
// Module   : encoder_emulator
// Brief    : Incremental quadrature encoder emulator with index and position
// Revision : 1.0
// ============================================================================
module encoder_emulator
  import encoder_pkg::*;
#(
  parameter int unsigned CLK_HZ        = c_DEF_CLK_HZ,
  parameter int unsigned EDGES_PER_REV = c_DEF_EDGES_PER_REV
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [c_RPM_W-1:0]        rpm_cmd,
  input  logic                      dir_cmd,
  input  logic                      load,
  input  logic                      enable,
  output logic                      enc_a,
  output logic                      enc_b,
  output logic                      enc_z,
  output logic                      step,
  output logic signed [c_POS_W-1:0] pos
);

  localparam longint unsigned c_MOD   = 64'(CLK_HZ) * 64'd60;
  localparam int unsigned     c_ACC_W = $clog2(c_MOD) + 1;
  localparam int unsigned     c_IDX_W = $clog2(EDGES_PER_REV);

  generate
    if ((EDGES_PER_REV < 4) || (EDGES_PER_REV > 1024) ||
        ((EDGES_PER_REV & (EDGES_PER_REV - 1)) != 0)) begin : g_bad_edges
      $error("EDGES_PER_REV must be a power of two in 4..1024");
    end
  endgenerate

  logic [c_RPM_W-1:0]        r_rpm_act;
  logic                      r_dir_act;
  quad_state_t               r_state;
  quad_state_t               w_state_next;
  logic [c_IDX_W-1:0]        r_idx;
  logic [c_IDX_W-1:0]        w_idx_next;
  logic signed [c_POS_W-1:0] r_pos;
  logic signed [c_POS_W-1:0] w_pos_next;
  logic                      r_step;
  logic                      r_z;
  logic [63:0]               w_inc_full;
  logic [c_ACC_W-1:0]        w_inc;
  logic                      w_nco_step;

  // Saturate at MOD so a fast command never asks for two edges in one cycle.
  always_comb begin
    w_inc_full = 64'(r_rpm_act) << c_IDX_W;
    w_inc      = (w_inc_full > c_MOD) ? c_ACC_W'(c_MOD) : c_ACC_W'(w_inc_full);
  end

  enc_rate_nco #(
    .MOD   (c_MOD),
    .ACC_W (c_ACC_W)
  ) u_nco (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .enable (enable),
    .inc    (w_inc),
    .step   (w_nco_step)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rpm_act <= '0;
      r_dir_act <= 1'b1;
    end else if (load) begin
      r_rpm_act <= rpm_cmd;
      r_dir_act <= dir_cmd;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_pos_next   = r_pos;
    if (w_nco_step) begin
      w_state_next = quad_next(r_state, r_dir_act);
      if (r_dir_act) begin
        w_idx_next = r_idx + 1'b1;
        w_pos_next = r_pos + 16'sd1;
      end else begin
        w_idx_next = r_idx - 1'b1;
        w_pos_next = r_pos - 16'sd1;
      end
    end
  end

  // Channels, index, position and step all change on the same edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S0;
      r_idx   <= '0;
      r_pos   <= '0;
      r_step  <= 1'b0;
      r_z     <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_pos   <= w_pos_next;
      r_step  <= w_nco_step;
      r_z     <= (w_idx_next == '0);
    end
  end

  assign enc_a = r_state[1];
  assign enc_b = r_state[0];
  assign enc_z = r_z;
  assign step  = r_step;
  assign pos   = r_pos;

endmodule
`default_nettype wire

// File: tb/tb_encoder_emulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_encoder_emulator
// Brief    : Self-checking bench for encoder_emulator (CLK_HZ=1000, 32 edges)
// Revision : 1.0
// ============================================================================
module tb_encoder_emulator;

  logic               CLK     = 1'b0;
  logic               RST_N   = 1'b0;
  logic [10:0]        rpm_cmd = '0;
  logic               dir_cmd = 1'b1;
  logic               load    = 1'b0;
  logic               enable  = 1'b0;
  logic               enc_a, enc_b, enc_z, step;
  logic signed [15:0] pos;

  encoder_emulator #(
    .CLK_HZ        (1000),
    .EDGES_PER_REV (32)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .rpm_cmd (rpm_cmd),
    .dir_cmd (dir_cmd),
    .load    (load),
    .enable  (enable),
    .enc_a   (enc_a),
    .enc_b   (enc_b),
    .enc_z   (enc_z),
    .step    (step),
    .pos     (pos)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int n_steps = 0;

  logic [1:0]         m_ab  = 2'b00;
  logic [4:0]         m_idx = 5'd0;
  logic signed [15:0] m_pos = 16'sd0;
  logic               m_dir = 1'b1;
  logic               cap_load = 1'b0;
  logic               cap_dir  = 1'b1;

  function automatic logic [1:0] next_ab(input logic [1:0] ab, input logic fwd);
    case (ab)
      2'b00:   return fwd ? 2'b10 : 2'b01;
      2'b10:   return fwd ? 2'b11 : 2'b00;
      2'b11:   return fwd ? 2'b01 : 2'b10;
      default: return fwd ? 2'b00 : 2'b11;
    endcase
  endfunction

  task automatic check(input string name, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Reference quadrature model, advanced on each observed step.
  always @(posedge CLK) begin
    cap_load <= load;
    cap_dir  <= dir_cmd;
  end

  always @(negedge CLK) begin
    if (!RST_N) begin
      m_ab  = 2'b00;
      m_idx = 5'd0;
      m_pos = 16'sd0;
      m_dir = 1'b1;
      check("rst_ab", {enc_a, enc_b}, 0);
      check("rst_z", enc_z, 1);
      check("rst_pos", pos, 0);
      check("rst_step", step, 0);
    end else begin
      if (step) begin
        n_steps++;
        m_ab  = next_ab(m_ab, m_dir);
        m_idx = m_dir ? m_idx + 5'd1 : m_idx - 5'd1;
        m_pos = m_dir ? m_pos + 16'sd1 : m_pos - 16'sd1;
      end
      check("mon_ab", {enc_a, enc_b}, m_ab);
      check("mon_pos", pos, m_pos);
      check("mon_z", enc_z, (m_idx == 5'd0));
      if (cap_load) m_dir = cap_dir;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic settle();
    @(negedge CLK);
    #1;
  endtask

  task automatic do_load(input int rpm, input logic dir);
    rpm_cmd = 11'(rpm);
    dir_cmd = dir;
    load    = 1'b1;
    tick(1);
    load    = 1'b0;
  endtask

  task automatic reset_dut();
    enable = 1'b0;
    load   = 1'b0;
    RST_N  = 1'b0;
    tick(2);
    RST_N  = 1'b1;
    tick(1);
  endtask

  typedef struct {
    int         rpm;
    logic       dir;
    int         cycles;
    int         steps;
    int         pos;
    logic [1:0] ab;
    logic       z;
  } vec_t;

  typedef struct {
    int         steps;
    int         pos;
    logic [1:0] ab;
    logic       z;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];

  initial begin
    int   base;
    exp_t e;

    vecs[0] = '{0,    1'b1, 100, 0,   0,   2'b00, 1'b1};
    vecs[1] = '{1875, 1'b1, 32,  32,  32,  2'b00, 1'b1};
    vecs[2] = '{100,  1'b1, 75,  4,   4,   2'b00, 1'b0};
    vecs[3] = '{1875, 1'b0, 1,   1,   -1,  2'b01, 1'b0};
    vecs[4] = '{1875, 1'b0, 32,  32,  -32, 2'b00, 1'b1};
    vecs[5] = '{2047, 1'b1, 10,  10,  10,  2'b11, 1'b0};
    vecs[6] = '{1875, 1'b1, 3,   3,   3,   2'b01, 1'b0};
    vecs[7] = '{937,  1'b1, 20,  9,   9,   2'b10, 1'b0};

    // Idle after reset with no load: nothing may move.
    tick(2);
    RST_N  = 1'b1;
    enable = 1'b1;
    base   = n_steps;
    tick(100);
    settle();
    check("idle_steps", n_steps - base, 0);
    check("idle_ab", {enc_a, enc_b}, 0);
    check("idle_z", enc_z, 1);
    check("idle_pos", pos, 0);

    foreach (vecs[i]) begin
      reset_dut();
      enable = 1'b1;
      sb.push_back('{vecs[i].steps, vecs[i].pos, vecs[i].ab, vecs[i].z});
      base = n_steps;
      do_load(vecs[i].rpm, vecs[i].dir);
      tick(vecs[i].cycles);
      settle();
      e = sb.pop_front();
      check($sformatf("v%0d_steps", i), n_steps - base, e.steps);
      check($sformatf("v%0d_pos", i), pos, e.pos);
      check($sformatf("v%0d_ab", i), {enc_a, enc_b}, e.ab);
      check($sformatf("v%0d_z", i), enc_z, e.z);
    end

    // Direction reversal arriving together with the fifth forward step.
    reset_dut();
    enable = 1'b1;
    do_load(1875, 1'b1);
    tick(4);
    do_load(1875, 1'b0);
    check("rev_pos5", pos, 5);
    check("rev_ab5", {enc_a, enc_b}, 2'b10);
    tick(1);
    check("rev_pos4", pos, 4);
    check("rev_ab4", {enc_a, enc_b}, 2'b00);
    tick(1);
    check("rev_pos3", pos, 3);
    check("rev_ab3", {enc_a, enc_b}, 2'b01);
    tick(3);
    check("rev_pos0", pos, 0);
    check("rev_z0", enc_z, 1);

    // A load of rpm=0 coinciding with a step still lets that step happen.
    reset_dut();
    enable = 1'b1;
    do_load(1875, 1'b1);
    tick(3);
    do_load(0, 1'b1);
    tick(5);
    check("ldstep_pos", pos, 4);

    // Reloading the same rate must not restart the accumulator.
    reset_dut();
    enable = 1'b1;
    do_load(100, 1'b1);
    tick(10);
    do_load(100, 1'b1);
    tick(8);
    check("acc_keep_pos", pos, 1);

    // Freeze with enable low, then an asynchronous reset mid-cycle.
    reset_dut();
    enable = 1'b1;
    do_load(1875, 1'b1);
    tick(5);
    settle();
    base   = n_steps;
    enable = 1'b0;
    tick(10);
    settle();
    check("frz_steps", n_steps - base, 0);
    check("frz_pos", pos, 5);
    check("frz_ab", {enc_a, enc_b}, 2'b10);
    #3;
    RST_N = 1'b0;
    #1;
    check("arst_ab", {enc_a, enc_b}, 0);
    check("arst_z", enc_z, 1);
    check("arst_pos", pos, 0);
    check("arst_step", step, 0);
    tick(2);
    RST_N  = 1'b1;
    enable = 1'b1;
    base   = n_steps;
    tick(20);
    settle();
    check("post_rst_steps", n_steps - base, 0);
    check("post_rst_pos", pos, 0);

    // Position wraps two's-complement at the positive limit.
    reset_dut();
    enable = 1'b1;
    do_load(1875, 1'b1);
    tick(32767);
    check("wrap_pos_max", pos, 32767);
    check("wrap_ab_max", {enc_a, enc_b}, 2'b01);
    tick(1);
    check("wrap_pos_min", pos, -32768);
    check("wrap_ab_min", {enc_a, enc_b}, 2'b00);
    check("wrap_z", enc_z, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
